// File: rtl/fetch_sched_if.sv
// fetch_sched_if: pixel stream in, buffer read strobe/address, aligned flags out.
// slave = scheduler side, master = source/sink side.
interface fetch_sched_if;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tuser;
  logic       s_tready;
  logic       m_tready;
  logic       rd_en;
  logic [9:0] rd_row;
  logic [9:0] rd_col;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tuser;
  logic       frame_done;

  modport slave (
    input  s_tvalid, s_tlast, s_tuser, m_tready,
    output s_tready, rd_en, rd_row, rd_col,
    output m_tvalid, m_tlast, m_tuser, frame_done
  );

  modport master (
    output s_tvalid, s_tlast, s_tuser, m_tready,
    input  s_tready, rd_en, rd_row, rd_col,
    input  m_tvalid, m_tlast, m_tuser, frame_done
  );
endinterface

// File: rtl/fetch_sched.sv
// fetch_sched: read scheduler for the 6-row rectification line buffer.
// Ports: clk, rst (async high), bus (fetch_sched_if.slave: stream in,
// rd_en/rd_row/rd_col, m_tvalid/m_tlast/m_tuser, frame_done).
// Option: define FETCH_SCHED_STATS_EN to add stall_cnt[15:0].
module fetch_sched #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 12,
  parameter int BUF_H  = 6,
  parameter int LEAD   = 2,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  fetch_sched_if.slave bus
`ifdef FETCH_SCHED_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, FILL, RUN, DRAIN, FLUSH
  } state_t;

  localparam logic [9:0] W_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] H_LAST = 10'(IMG_H - 1);
  localparam logic [9:0] H_ALL  = 10'(IMG_H);
  localparam logic [9:0] B_ALL  = 10'(BUF_H);
  localparam logic [9:0] LEAD1  = 10'(LEAD + 1);

  state_t            state_q;
  logic [9:0]        wr_rows_q, wr_rows_d;
  logic [9:0]        rd_row_q, rd_row_d;
  logic [9:0]        rd_col_q, rd_col_d;
  logic [RD_LAT-1:0] vld_q, lst_q, usr_q;
  logic              frame_done_q;

  logic [9:0] occ;
  logic       s_rdy;
  logic       accept;
  logic       row_done;
  logic       avail;
  logic       rd_en;
  logic       last_px;
  logic       start;

  assign occ = wr_rows_q - rd_row_q;

  // occ only moves on row boundaries, so a row begun at BUF_H-1
  // keeps being accepted until its tlast lifts occ to BUF_H.
  assign s_rdy = (state_q == FILL || state_q == RUN)
              && (wr_rows_q < H_ALL)
              && (occ < B_ALL);

  assign accept   = bus.s_tvalid && s_rdy;
  assign row_done = accept && bus.s_tlast;

  assign avail = (wr_rows_q >= rd_row_q + LEAD1)
              || (wr_rows_q == H_ALL);

  assign rd_en = bus.m_tready
              && ((state_q == RUN && avail)
                  || state_q == DRAIN);

  assign last_px = rd_en
                && rd_row_q == H_LAST
                && rd_col_q == W_LAST;

  assign start = state_q == IDLE
              && bus.s_tvalid && bus.s_tuser;

  always_comb begin
    wr_rows_d = wr_rows_q + {9'd0, row_done};
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    if (rd_en) begin
      if (rd_col_q == W_LAST) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + 10'd1;
      end else begin
        rd_col_d = rd_col_q + 10'd1;
      end
    end
    // Frame end: clear counters so FLUSH/IDLE see an empty buffer.
    if (last_px) begin
      wr_rows_d = '0;
      rd_row_d  = '0;
      rd_col_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_rows_q    <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      vld_q        <= '0;
      lst_q        <= '0;
      usr_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_rows_q    <= wr_rows_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      frame_done_q <= 1'b0;

      if (bus.m_tready) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          vld_q[i] <= vld_q[i-1];
          lst_q[i] <= lst_q[i-1];
          usr_q[i] <= usr_q[i-1];
        end
        vld_q[0] <= rd_en;
        lst_q[0] <= rd_en && rd_col_q == W_LAST;
        usr_q[0] <= rd_en && rd_row_q == '0
                          && rd_col_q == '0;
      end

      unique case (state_q)
        IDLE: begin
          if (start) state_q <= FILL;
        end
        FILL: begin
          if (wr_rows_q >= LEAD1) state_q <= RUN;
        end
        RUN: begin
          if (last_px) state_q <= FLUSH;
          else if (wr_rows_q == H_ALL) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_px) state_q <= FLUSH;
        end
        FLUSH: begin
          if (~|vld_q) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_tready   = s_rdy;
  assign bus.rd_en      = rd_en;
  assign bus.rd_row     = rd_row_q;
  assign bus.rd_col     = rd_col_q;
  assign bus.m_tvalid   = vld_q[RD_LAT-1];
  assign bus.m_tlast    = lst_q[RD_LAT-1];
  assign bus.m_tuser    = usr_q[RD_LAT-1];
  assign bus.frame_done = frame_done_q;

`ifdef FETCH_SCHED_STATS_EN
  logic [15:0] stall_q;
  logic        stall;

  // Downstream ready but no row available yet: input is too slow.
  assign stall = (state_q == RUN || state_q == DRAIN)
              && bus.m_tready && !rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start) begin
      stall_q <= '0;
    end else if (stall && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed scenario tests for fetch_sched.
// Tasks per scenario, inline checks, one summary line.
module tb_fetch_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sched_if bus();

`ifdef FETCH_SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fetch_sched dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_SCHED_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int vec = 0;
  int bad = 0;

  bit src_on;
  int src_gap, gapc, px, user_px, rdy_mode;

  int cyc, m_wr, n_rd, n_out, n_last, n_user, n_done;
  int ord_err, flag_err, lat_err, max_occ;
  int first_rd_wr, cyc3, stall_exp, e_row, e_col;
  bit rd_d1, rd_d2, check_lat;

  task automatic tick();
    bit acc;
    int occ;
    @(negedge clk);
    cyc++;
    acc = bus.s_tvalid && bus.s_tready;
    if (cyc3 >= 0 && cyc >= cyc3 + 2 && n_rd < 192
        && bus.m_tready && !bus.rd_en)
      stall_exp++;
    if (acc && bus.s_tlast) begin
      m_wr++;
      if (m_wr == 3) cyc3 = cyc;
    end
    occ = m_wr - n_rd / 16;
    if (occ > max_occ) max_occ = occ;
    if (bus.rd_en) begin
      if (n_rd == 0) first_rd_wr = m_wr;
      if (bus.rd_row !== 10'(e_row)
          || bus.rd_col !== 10'(e_col))
        ord_err++;
      e_col++;
      if (e_col == 16) begin
        e_col = 0;
        e_row++;
      end
      n_rd++;
    end
    if (check_lat && bus.m_tvalid !== rd_d2) lat_err++;
    rd_d2 = rd_d1;
    rd_d1 = bus.rd_en;
    if (bus.m_tvalid && bus.m_tready) begin
      if (bus.m_tlast !== (n_out % 16 == 15)
          || bus.m_tuser !== (n_out == 0))
        flag_err++;
      if (bus.m_tlast) n_last++;
      if (bus.m_tuser) n_user++;
      n_out++;
    end
    if (bus.frame_done) begin
      n_done++;
      if (n_out != 192) flag_err++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      px++;
      gapc = src_gap;
    end else if (gapc > 0) begin
      gapc--;
    end
    bus.s_tvalid = src_on && px < 192 && gapc == 0;
    bus.s_tlast  = (px % 16 == 15);
    bus.s_tuser  = (px == 0) || (px == user_px);
    case (rdy_mode)
      0: bus.m_tready = 1'b1;
      1: bus.m_tready = ~bus.m_tready;
      default: bus.m_tready = 1'b0;
    endcase
  endtask

  task automatic start_frame(input int gap, input int mode,
                             input int upx);
    cyc = 0; m_wr = 0; n_rd = 0; n_out = 0;
    n_last = 0; n_user = 0; n_done = 0;
    ord_err = 0; flag_err = 0; lat_err = 0;
    max_occ = 0; first_rd_wr = -1; cyc3 = -1;
    stall_exp = 0; e_row = 0; e_col = 0;
    rd_d1 = 0; rd_d2 = 0;
    px = 0; gapc = 0; src_gap = gap;
    user_px = upx; rdy_mode = mode; src_on = 1;
    bus.m_tready = (mode != 2);
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = 1'b0;
    bus.s_tuser  = 1'b1;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      tick();
      n++;
    end
    vec++;
    if (n_done == 0) begin
      bad++;
      $display("FAIL timeout: frame_done count %0d after %0d cycles, want 1",
               n_done, budget);
    end
    repeat (8) tick();
    src_on = 0;
  endtask

  task automatic test_reset();
    logic [5:0] fl;
    rst = 1'b1;
    src_on = 0; px = 5; user_px = -1; gapc = 0;
    src_gap = 0; rdy_mode = 0; cyc3 = -1;
    bus.s_tvalid = 0; bus.s_tlast = 0;
    bus.s_tuser = 0; bus.m_tready = 1;
    repeat (3) tick();
    fl = {bus.s_tready, bus.rd_en, bus.m_tvalid,
          bus.m_tlast, bus.m_tuser, bus.frame_done};
    vec++;
    if (fl !== 6'd0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000", fl);
    end
    vec++;
    if (bus.rd_row !== 10'd0 || bus.rd_col !== 10'd0) begin
      bad++;
      $display("FAIL reset_rowcol: got %0d,%0d want 0,0",
               bus.rd_row, bus.rd_col);
    end
    tick();
    rst = 1'b0;
    src_on = 1;
    repeat (4) tick();
    vec++;
    if (bus.s_tready !== 1'b0 || bus.rd_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_user: tready %b rd_en %b want 0 0",
               bus.s_tready, bus.rd_en);
    end
    src_on = 0;
    tick();
  endtask

  task automatic test_basic();
    start_frame(0, 0, -1);
    check_lat = 1;
    run_to_done(3000);
    check_lat = 0;
    vec++;
    if (first_rd_wr !== 3) begin
      bad++;
      $display("FAIL first_rd_rows: got %0d want 3", first_rd_wr);
    end
    vec++;
    if (n_rd !== 192) begin
      bad++;
      $display("FAIL basic_rd_cnt: got %0d want 192", n_rd);
    end
    vec++;
    if (n_out !== 192) begin
      bad++;
      $display("FAIL basic_out_cnt: got %0d want 192", n_out);
    end
    vec++;
    if (n_last !== 12 || n_user !== 1) begin
      bad++;
      $display("FAIL basic_last_user: got %0d/%0d want 12/1",
               n_last, n_user);
    end
    vec++;
    if (n_done !== 1) begin
      bad++;
      $display("FAIL basic_done: got %0d want 1", n_done);
    end
    vec++;
    if (ord_err !== 0 || flag_err !== 0 || lat_err !== 0) begin
      bad++;
      $display("FAIL basic_align: ord %0d flag %0d lat %0d want 0",
               ord_err, flag_err, lat_err);
    end
  endtask

  task automatic test_hold();
    start_frame(0, 2, -1);
    repeat (200) tick();
    vec++;
    if (m_wr !== 6 || n_rd !== 0) begin
      bad++;
      $display("FAIL hold_fill: rows %0d reads %0d want 6 0",
               m_wr, n_rd);
    end
    vec++;
    if (bus.s_tready !== 1'b0) begin
      bad++;
      $display("FAIL hold_tready: got %b want 0", bus.s_tready);
    end
    rdy_mode = 0;
    run_to_done(3000);
    vec++;
    if (n_out !== 192 || n_done !== 1) begin
      bad++;
      $display("FAIL hold_out: got %0d/%0d want 192/1",
               n_out, n_done);
    end
    vec++;
    if (max_occ !== 6) begin
      bad++;
      $display("FAIL hold_occ: got %0d want 6", max_occ);
    end
    vec++;
    if (ord_err !== 0 || flag_err !== 0) begin
      bad++;
      $display("FAIL hold_order: ord %0d flag %0d want 0",
               ord_err, flag_err);
    end
  endtask

  task automatic test_toggle();
    start_frame(0, 1, -1);
    run_to_done(4000);
    vec++;
    if (n_out !== 192 || n_last !== 12 || n_user !== 1) begin
      bad++;
      $display("FAIL toggle_cnt: got %0d/%0d/%0d want 192/12/1",
               n_out, n_last, n_user);
    end
    vec++;
    if (ord_err !== 0 || flag_err !== 0) begin
      bad++;
      $display("FAIL toggle_align: ord %0d flag %0d want 0",
               ord_err, flag_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] fl;
    int n = 0;
    start_frame(0, 0, -1);
    while (m_wr < 5 && n < 1000) begin
      tick();
      n++;
    end
    vec++;
    if (m_wr !== 5) begin
      bad++;
      $display("FAIL mid_reach: rows %0d want 5", m_wr);
    end
    #2 rst = 1'b1;
    #1;
    fl = {bus.s_tready, bus.rd_en, bus.m_tvalid,
          bus.m_tlast, bus.m_tuser, bus.frame_done};
    vec++;
    if (fl !== 6'd0) begin
      bad++;
      $display("FAIL mid_rst_flags: got %b want 000000", fl);
    end
    vec++;
    if (bus.rd_row !== 10'd0 || bus.rd_col !== 10'd0) begin
      bad++;
      $display("FAIL mid_rst_rowcol: got %0d,%0d want 0,0",
               bus.rd_row, bus.rd_col);
    end
    src_on = 0;
    bus.s_tvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    start_frame(0, 0, -1);
    run_to_done(3000);
    vec++;
    if (n_out !== 192 || n_user !== 1 || ord_err !== 0) begin
      bad++;
      $display("FAIL mid_restart: out %0d user %0d ord %0d want 192 1 0",
               n_out, n_user, ord_err);
    end
  endtask

  task automatic test_tuser_again();
    start_frame(0, 0, 48);
    run_to_done(3000);
    vec++;
    if (n_out !== 192 || n_user !== 1 || n_done !== 1) begin
      bad++;
      $display("FAIL tuser_again: out %0d user %0d done %0d want 192 1 1",
               n_out, n_user, n_done);
    end
    vec++;
    if (ord_err !== 0 || flag_err !== 0) begin
      bad++;
      $display("FAIL tuser_order: ord %0d flag %0d want 0",
               ord_err, flag_err);
    end
  endtask

`ifdef FETCH_SCHED_STATS_EN
  task automatic test_stats();
    start_frame(4, 0, -1);
    run_to_done(5000);
    vec++;
    if (stall_cnt == 16'd0 || int'(stall_cnt) !== stall_exp) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want %0d (nonzero)",
               stall_cnt, stall_exp);
    end
    vec++;
    if (n_out !== 192) begin
      bad++;
      $display("FAIL stats_out: got %0d want 192", n_out);
    end
  endtask
`endif

  initial begin
    check_lat = 0;
    test_reset();
    test_basic();
    test_hold();
    test_toggle();
    test_reset_mid();
    test_tuser_again();
`ifdef FETCH_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sched.md
Name: fetch_sched

Overview:
- Read-side scheduler for the rectification line buffer (6-row circular image buffer + bilinear fetch).
- Tracks how many input rows have been written versus consumed, throttles the input stream so unread rows are never overwritten, and walks output raster coordinates.
- Issues one buffer read per output pixel, then aligns valid/last/user flags with the buffer's fixed read latency.
- Sits between the AXI-Stream style pixel input, the fetch datapath and the downstream interpolator.

Parameters:
- IMG_W, 16: pixels per row (input and output).
- IMG_H, 12: rows per frame.
- BUF_H, 6: rows held in the circular buffer.
- LEAD, 2: rows that must be written beyond the current output row before that row may be read (covers the vertical remap range).
- RD_LAT, 2: cycles from rd_en to buffer data valid.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous active-high reset.
- s_tvalid in 1: input pixel valid.
- s_tlast in 1: last pixel of input row.
- s_tuser in 1: first pixel of frame.
- s_tready out 1: input accepted this cycle.
- m_tready in 1: downstream ready; low freezes issue and the flag pipeline.
- rd_en out 1: buffer read strobe (one per output pixel).
- rd_row out 10: output row index, 0..IMG_H-1.
- rd_col out 10: output column index, 0..IMG_W-1.
- m_tvalid out 1: fetched pixel valid, rd_en delayed RD_LAT enabled cycles.
- m_tlast out 1: aligned end-of-row flag.
- m_tuser out 1: aligned start-of-frame flag.
- frame_done out 1: one-cycle pulse after the last output pixel leaves the pipeline.

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE, all counters 0.
  - s_tready=0, rd_en=0, m_tvalid=0, m_tlast=0, m_tuser=0, frame_done=0, rd_row=0, rd_col=0.
- Counters:
  - wr_rows (0..IMG_H) increments on accepted beat with s_tlast.
  - rd_row and rd_col advance on each rd_en: rd_col wraps IMG_W-1→0 and increments rd_row.
  - occupancy = wr_rows - rd_row, unsigned, 10-bit; never exceeds BUF_H.
- Input gating:
  - s_tready = (state in FILL, RUN) && (wr_rows < IMG_H) && (occupancy < BUF_H).
  - Exception: occupancy == BUF_H-1 mid-row is allowed until the row completes.
  - A beat is accepted iff s_tvalid && s_tready.
- States:
  - IDLE: s_tready=0. On s_tvalid && s_tuser → FILL. That beat is accepted in the cycle after the transition, so the source must hold it.
  - FILL: accept input; no reads. When wr_rows >= LEAD+1 → RUN.
  - RUN: rd_en = m_tready && ((wr_rows >= rd_row+LEAD+1) || wr_rows == IMG_H).
    - Input and read may occur in the same cycle; both update independently.
    - When wr_rows == IMG_H → DRAIN.
  - DRAIN: s_tready=0; rd_en = m_tready. After the rd_en at (IMG_H-1, IMG_W-1) → FLUSH.
  - FLUSH: wait until the flag pipeline is empty, then assert frame_done for 1 cycle → IDLE with counters cleared.
- Flag pipeline: RD_LAT-stage shift register carrying {valid, last=(rd_col==IMG_W-1), user=(rd_row==0 && rd_col==0)}.
  - Advances only when m_tready=1.
  - m_tvalid holds its value while m_tready=0.
- s_tuser seen in FILL/RUN/DRAIN: ignored; no restart.
- s_tlast must occur every IMG_W beats; no length checking.

Optional Feature:
- Macro: FETCH_SCHED_STATS_EN.
- Defined: adds output stall_cnt [15:0].
  - Counts cycles in RUN/DRAIN with m_tready=1 and rd_en=0, i.e. stalls waiting for input rows.
  - Saturates at 16'hFFFF; clears on reset and on IDLE→FILL.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Continuous input, m_tready=1, defaults → first rd_en after the 3rd s_tlast. Exactly 192 rd_en; m_tvalid 2 cycles after each rd_en; 12 m_tlast; 1 m_tuser; one frame_done.
- Downstream holds m_tready=0 → s_tready drops when occupancy reaches 6. No overwrite: wr_rows - rd_row never exceeds 6. On release, output resumes in order with no lost pixel.
- m_tready toggled every cycle → m_tvalid/m_tlast remain aligned to rd_col==15. Total m_tvalid beats = 192.
- rst pulsed mid-frame (row 5) → all outputs 0 asynchronously. Next s_tuser restarts at rd_row=0, rd_col=0.
- s_tuser reasserted at row 3 → ignored; frame completes with 192 outputs.
- With FETCH_SCHED_STATS_EN, input gaps of 4 cycles per pixel → stall_cnt > 0 and equal to the counted idle RUN cycles. Without the macro, the build has no stall_cnt port.
